register_file_sb: RTL and testbench
===================================

REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001: Parameter DATA_W, default 32, is the register and data-bus width in bits.
REQ-002: Parameter ADDR_W, default 5, is the register address width; NREGS = 2**ADDR_W.
REQ-003: Parameter ZERO_REG, default 1, hardwires register 0 to zero and never marks it busy when set to 1.
REQ-004: Port clk, input, 1 bit, is the single clock; all state updates on the rising edge.
REQ-005: Port rst_n, input, 1 bit, is the reset; it is synchronous and active-low.
REQ-006: Port ra_addr, input, ADDR_W bits, is the read port A address.
REQ-007: Port rb_addr, input, ADDR_W bits, is the read port B address.
REQ-008: Port busA, output, DATA_W bits, is the read port A data (combinational).
REQ-009: Port busB, output, DATA_W bits, is the read port B data (combinational).
REQ-010: Port we, input, 1 bit, is the writeback enable.
REQ-011: Port wa, input, ADDR_W bits, is the writeback address.
REQ-012: Port wd, input, DATA_W bits, is the writeback data.
REQ-013: Port issue_valid, input, 1 bit, marks an instruction issuing with a destination register.
REQ-014: Port issue_rd, input, ADDR_W bits, is the destination of the issuing instruction.
REQ-015: Port hazard, output, 1 bit, is high when either read source awaits an outstanding write.
REQ-016: Port busy_cnt, output, ADDR_W+1 bits, is the number of registers currently marked busy.

Function
REQ-017: At each rising clk edge with rst_n=1 and we=1, the block SHALL write wd to reg[wa], except that a write to wa=0 is discarded when ZERO_REG=1.
REQ-018: busA SHALL equal reg[ra_addr], and busB SHALL equal reg[rb_addr], with zero read-to-data latency.
REQ-019: The read ports SHALL bypass in the same cycle: if we=1, wa==ra_addr and the write is not discarded, busA SHALL equal wd. The same rule applies to busB with rb_addr.
REQ-020: A read of address 0 SHALL return 0 when ZERO_REG=1, including when we=1 and wa=0.
REQ-021: The scoreboard SHALL hold one busy bit per register.
REQ-022: On issue_valid=1, the busy bit of issue_rd SHALL be set at the next edge, except when issue_rd=0 and ZERO_REG=1.
REQ-023: On we=1, the busy bit of wa SHALL be cleared at the next edge.
REQ-024: If issue_valid=1 and we=1 in the same cycle with issue_rd==wa, the busy bit SHALL end set, because set wins over clear (a new producer is pending).
REQ-025: If issue_valid=1 and we=1 in the same cycle with issue_rd!=wa, the set and the clear SHALL both take effect.
REQ-026: hazard SHALL equal (busy[ra_addr] AND NOT bypassA) OR (busy[rb_addr] AND NOT bypassB), where bypassX means a same-cycle write to that address per REQ-019.
REQ-027: hazard SHALL be combinational with no registered delay.
REQ-028: A writeback to a register whose busy bit is not set SHALL still write the data and leave the busy bit clear; this is not an error.
REQ-029: Issuing to a register that is already busy SHALL leave it busy and SHALL not change busy_cnt.
REQ-030: busy_cnt SHALL be a registered count of busy bits, updated on the same edge as the busy bits.
REQ-031: busy_cnt SHALL be +1 for a net set, -1 for a net clear, and unchanged for no change or a set and a clear on different registers.
REQ-032: busy_cnt SHALL saturate at NREGS and SHALL never wrap.

Reset
REQ-033: When rst_n=0 at a rising edge, all registers SHALL become 0, all busy bits SHALL become 0, and busy_cnt SHALL become 0.
REQ-034: Reset SHALL override any concurrent we or issue_valid.
REQ-035: Reset SHALL be honoured mid-operation with no partial writes retained.
REQ-036: After reset, busA, busB and hazard SHALL be 0 until the first write or issue.

Verification
REQ-037: Reset, then set we=1, wa=5, wd=0xDEADBEEF, ra_addr=5 in one cycle -> busA=0xDEADBEEF in the same cycle (bypass), and reg[5] reads 0xDEADBEEF afterwards with we=0.
REQ-038: Set we=1, wa=0, wd=0x12345678, then read rb_addr=0 -> busB=0 in the write cycle and afterwards.
REQ-039: Issue rd=7, then next cycle set ra_addr=7 -> hazard=1 and busy_cnt=1; then writeback wa=7 with ra_addr=7 -> hazard=0 in that cycle, and busy_cnt=0 after the edge.
REQ-040: In one cycle set issue_valid=1 with issue_rd=9, and we=1 with wa=9 while busy[9]=1 -> busy[9] stays 1, busy_cnt is unchanged, and reg[9]=wd.
REQ-041: Issue rd=3, then rd=4, then pulse rst_n=0 for one cycle while we=1, wa=4 -> after the edge busy_cnt=0, hazard=0 for sources 3 and 4, and reg[4]=0.
REQ-042: Issue all 31 non-zero registers with ZERO_REG=1 -> busy_cnt=31; then issue rd=0 -> busy_cnt stays 31.

Source files
------------

// File: rtl/register_file_sb.sv
// register_file_sb
//   Register file with two combinational read ports, one writeback port and a
//   busy-bit scoreboard for tracking registers that await an outstanding write.
//   Read ports bypass a same-cycle writeback. hazard flags a read source that
//   is still busy and is not being written back this cycle.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   ra_addr, rb_addr    read addresses          -> busA, busB (combinational)
//   we, wa, wd          writeback enable/address/data
//   issue_valid,        instruction issuing with destination issue_rd
//   issue_rd
//   hazard              a read source awaits an outstanding write (combinational)
//   busy_cnt            registered count of busy registers
module register_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              hazard,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int                NREGS   = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W+1)'(NREGS);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic wr_en, set_en, set_new, clr_eff;
  logic byp_a, byp_b, zero_a, zero_b;

  // A write to register 0 is dropped when it is hardwired to zero.
  assign wr_en  = we && !((ZERO_REG != 0) && (wa == '0));
  assign set_en = issue_valid && !((ZERO_REG != 0) && (issue_rd == '0));

  assign byp_a  = wr_en && (wa == ra_addr);
  assign byp_b  = wr_en && (wa == rb_addr);
  assign zero_a = (ZERO_REG != 0) && (ra_addr == '0);
  assign zero_b = (ZERO_REG != 0) && (rb_addr == '0);

  assign busA = zero_a ? '0 : (byp_a ? wd : regs_q[ra_addr]);
  assign busB = zero_b ? '0 : (byp_b ? wd : regs_q[rb_addr]);

  assign hazard = (busy_q[ra_addr] && !byp_a) || (busy_q[rb_addr] && !byp_b);

  // Count deltas: a set only counts if the bit was clear; a clear only counts
  // if the bit was set and is not simultaneously re-set by a new producer.
  assign set_new = set_en && !busy_q[issue_rd];
  assign clr_eff = we && busy_q[wa] && !(set_en && (issue_rd == wa));

  always_comb begin
    busy_d = busy_q;
    if (we)     busy_d[wa]       = 1'b0;
    if (set_en) busy_d[issue_rd] = 1'b1;  // set wins over clear
  end

  always_comb begin
    cnt_d = cnt_q;
    if (set_new && !clr_eff) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else if (clr_eff && !set_new) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) regs_q[wa] <= wd;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] ra_addr, rb_addr, wa, issue_rd;
  logic [DW-1:0] busA, busB, wd;
  logic          we, issue_valid, hazard;
  logic [AW:0]   busy_cnt;

  register_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .busA(busA), .busB(busB), .we(we), .wa(wa), .wd(wd),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .hazard(hazard), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays of register contents and busy flags.
  logic [DW-1:0] mreg [NR];
  bit            mbusy [NR];
  int            mcnt;
  int            nvec = 0, nerr = 0;
  bit            chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit m_byp(input logic [AW-1:0] a);
    return we && (wa == a) && (a != 0);
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0)    return '0;
    if (m_byp(a))  return wd;
    return mreg[a];
  endfunction

  function automatic bit m_hazard();
    return (mbusy[ra_addr] && !m_byp(ra_addr)) || (mbusy[rb_addr] && !m_byp(rb_addr));
  endfunction

  // Advance one clock edge, updating the model from the inputs seen at it.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin mreg[i] = '0; mbusy[i] = 1'b0; end
    end else begin
      if (we && wa != 0) mreg[wa] = wd;
      if (we) mbusy[wa] = 1'b0;
      if (issue_valid && issue_rd != 0) mbusy[issue_rd] = 1'b1;
    end
    mcnt = 0;
    for (int i = 0; i < NR; i++) mcnt += int'(mbusy[i]);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; issue_valid = 1'b0; wa = '0; wd = '0; issue_rd = '0;
  endtask

  // Compare process: every cycle, outputs versus model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busA",     64'(busA),     64'(m_read(ra_addr)));
      chk("busB",     64'(busB),     64'(m_read(rb_addr)));
      chk("hazard",   64'(hazard),   64'(m_hazard()));
      chk("busy_cnt", 64'(busy_cnt), 64'(mcnt));
    end
  end

  initial begin
    rst_n = 1'b0; idle(); ra_addr = 5'd5; rb_addr = 5'd3;
    for (int i = 0; i < NR; i++) begin mreg[i] = 'x; mbusy[i] = 1'b0; end
    mcnt = 0;
    tick(); tick();
    rst_n = 1'b1; chk_en = 1'b1;
    #1;
    chk("rst_busA", 64'(busA), 64'd0);
    chk("rst_busB", 64'(busB), 64'd0);
    chk("rst_hazard", 64'(hazard), 64'd0);
    chk("rst_cnt", 64'(busy_cnt), 64'd0);

    // bypass then stored value
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra_addr = 5'd5; #1;
    chk("byp_busA", 64'(busA), 64'hDEADBEEF);
    tick(); idle(); #1;
    chk("stored_busA", 64'(busA), 64'hDEADBEEF);

    // register 0 stays zero
    we = 1'b1; wa = 5'd0; wd = 32'h12345678; rb_addr = 5'd0; #1;
    chk("r0_wr_busB", 64'(busB), 64'd0);
    tick(); idle(); #1;
    chk("r0_after_busB", 64'(busB), 64'd0);

    // issue -> hazard, writeback clears it with bypass
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick(); idle(); ra_addr = 5'd7; #1;
    chk("iss7_hazard", 64'(hazard), 64'd1);
    chk("iss7_cnt", 64'(busy_cnt), 64'd1);
    we = 1'b1; wa = 5'd7; wd = 32'h00000777; #1;
    chk("wb7_hazard", 64'(hazard), 64'd0);
    tick(); idle(); #1;
    chk("wb7_cnt", 64'(busy_cnt), 64'd0);

    // same-cycle issue and writeback to a busy register: set wins
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    we = 1'b1; wa = 5'd9; wd = 32'hCAFE0009;
    tick(); idle(); ra_addr = 5'd9; #1;
    chk("sw9_cnt", 64'(busy_cnt), 64'd1);
    chk("sw9_hazard", 64'(hazard), 64'd1);
    we = 1'b1; wa = 5'd9; wd = 32'hCAFE0009; #1;
    chk("sw9_data", 64'(busA), 64'hCAFE0009);
    tick(); idle();

    // reset mid-operation overrides a concurrent write
    issue_valid = 1'b1; issue_rd = 5'd3; tick();
    issue_rd = 5'd4; tick(); idle();
    rst_n = 1'b0; we = 1'b1; wa = 5'd4; wd = 32'hBAD00004;
    tick(); rst_n = 1'b1; idle(); ra_addr = 5'd3; rb_addr = 5'd4; #1;
    chk("mid_rst_cnt", 64'(busy_cnt), 64'd0);
    chk("mid_rst_hazard", 64'(hazard), 64'd0);
    chk("mid_rst_reg4", 64'(busB), 64'd0);

    // fill the scoreboard; register 0 never counts
    for (int r = 1; r < NR; r++) begin
      issue_valid = 1'b1; issue_rd = AW'(r); tick();
    end
    idle(); #1;
    chk("full_cnt", 64'(busy_cnt), 64'd31);
    issue_valid = 1'b1; issue_rd = 5'd0; tick(); idle(); #1;
    chk("full_r0_cnt", 64'(busy_cnt), 64'd31);
    // re-issue to a busy register leaves the count alone
    issue_valid = 1'b1; issue_rd = 5'd12; tick(); idle(); #1;
    chk("reissue_cnt", 64'(busy_cnt), 64'd31);

    // randomized traffic, half the time on a narrow address range for collisions
    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] hi;
      hi          = ($urandom_range(0, 1) == 0) ? 5'd3 : 5'd31;
      rst_n       = ($urandom_range(0, 99) != 0);
      we          = ($urandom_range(0, 2) != 0);
      issue_valid = ($urandom_range(0, 2) != 0);
      wa          = AW'($urandom_range(0, int'(hi)));
      issue_rd    = AW'($urandom_range(0, int'(hi)));
      ra_addr     = AW'($urandom_range(0, int'(hi)));
      rb_addr     = AW'($urandom_range(0, int'(hi)));
      wd          = $urandom;
      tick();
    end
    rst_n = 1'b1; idle();
    @(negedge clk); #1;
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
